cl_seq_divider: RTL and testbench

Sequential divider that undoes the work of the team's combinational add/multiply datapath. It takes a 2·DATA_WIDTH-bit dividend (the product width of the multiplier) and a DATA_WIDTH-bit divisor, and returns quotient and remainder. The mode is selected per operation:
- carry-less polynomial division over GF(2)[x], used for GF reduction and for checking carry-less products;
- ordinary unsigned integer division.

It is a radix-2 shift/subtract engine producing one quotient bit per clock, with a start/busy/done handshake.

---
 rtl/cl_seq_divider.sv | 165 ++++++++++++++++
 tb/tb_cl_seq_divider.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/cl_seq_divider.sv
// cl_seq_divider: radix-2 sequential divider, one quotient bit per clock.
//   Divides a 2*DATA_WIDTH dividend by a DATA_WIDTH divisor.
//   carry_option=1 selects unsigned restoring integer division.
//   carry_option=0 selects carry-less division over GF(2)[x].
// Ports: clk/rst_n (async active-low); start (sampled only when idle);
//   carry_option, dividend and divisor are latched on the accepted start;
//   busy (high from the accepting edge through the last step);
//   done (one-cycle pulse, never together with busy);
//   div_by_zero, quotient and remainder are valid with done and held
//   until the next accepted start.
// Latency: done appears after edge E+2*DATA_WIDTH+1, where E is the start edge.
// Issue interval: a held start is re-accepted during the done cycle,
//   giving one operation every 2*DATA_WIDTH+2 cycles.
module cl_seq_divider #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    carry_option,
  input  logic [2*DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0]   divisor,
  output logic                    busy,
  output logic                    done,
  output logic                    div_by_zero,
  output logic [2*DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0]   remainder
);

  localparam int QW    = 2 * DATA_WIDTH;
  localparam int CNT_W = $clog2(QW + 1);
  localparam int DEG_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [QW-1:0]         dvd_q;    // dividend, rotated left once per step
  logic [DATA_WIDTH-1:0] dvs_q;
  logic                  mode_q;
  logic [DEG_W-1:0]      deg_q;
  logic [DATA_WIDTH:0]   rem_q;    // partial remainder R
  logic [QW-1:0]         quo_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  done_q;
  logic                  dbz_q;

  // Index of the most significant set bit. Zero for a zero input; that
  // case is overridden by the divide-by-zero forcing at completion.
  function automatic logic [DEG_W-1:0] msb_index(input logic [DATA_WIDTH-1:0] v);
    logic [DEG_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (v[i]) idx = DEG_W'(i);
    end
    return idx;
  endfunction

  // ---------------------------------------------------------------------------
  // Step datapath
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH:0] r_sh;
  logic [DATA_WIDTH:0] r_sub;
  logic [DATA_WIDTH:0] r_xor;
  logic [DATA_WIDTH:0] r_nxt;
  logic                r_ge;
  logic                q_bit;

  always_comb begin
    r_sh  = {rem_q[DATA_WIDTH-1:0], dvd_q[QW-1]};
    r_ge  = (r_sh >= {1'b0, dvs_q});
    r_sub = r_sh - {1'b0, dvs_q};
    r_xor = r_sh ^ {1'b0, dvs_q};
    q_bit = 1'b0;
    r_nxt = r_sh;
    if (mode_q) begin
      q_bit = r_ge;
      if (r_ge) r_nxt = r_sub;
    end else begin
      // R has degree < deg before the shift, so after the shift only
      // bit deg can reach the divisor's degree.
      q_bit = r_sh[deg_q];
      if (r_sh[deg_q]) r_nxt = r_xor;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_RUN;
      // The counter reaches zero on the last step; finish then.
      S_RUN:  if (cnt_q == CNT_W'(1)) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand, remainder and quotient registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      mode_q <= 1'b0;
      deg_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
    end else begin
      done_q <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            dvd_q  <= dividend;
            dvs_q  <= divisor;
            mode_q <= carry_option;
            deg_q  <= msb_index(divisor);
            rem_q  <= '0;
            quo_q  <= '0;
            dbz_q  <= 1'b0;
            cnt_q  <= CNT_W'(QW);
          end
        end
        S_RUN: begin
          rem_q <= r_nxt;
          quo_q <= {quo_q[QW-2:0], q_bit};
          // Rotating rather than shifting leaves the original dividend
          // in place at the end, for the divide-by-zero remainder.
          dvd_q <= {dvd_q[QW-2:0], dvd_q[QW-1]};
          cnt_q <= cnt_q - CNT_W'(1);
        end
        S_DONE: begin
          if (dvs_q == '0) begin
            dbz_q <= 1'b1;
            quo_q <= '1;
            rem_q <= {1'b0, dvd_q[DATA_WIDTH-1:0]};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state != S_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_cl_seq_divider.sv
// Scoreboard bench for cl_seq_divider at DATA_WIDTH=8. Stimulus pushes the
// expected result (with its accept edge) into a queue; a monitor pops and
// compares on every done pulse, including the done latency.
module tb_cl_seq_divider;

  localparam int W   = 8;
  localparam int LAT = 2 * W + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          carry_option = 1'b0;
  logic [2*W-1:0] dividend = '0;
  logic [W-1:0]   divisor = '0;
  logic          busy, done, div_by_zero;
  logic [2*W-1:0] quotient;
  logic [W-1:0]   remainder;

  cl_seq_divider #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .carry_option (carry_option),
    .dividend     (dividend),
    .divisor      (divisor),
    .busy         (busy),
    .done         (done),
    .div_by_zero  (div_by_zero),
    .quotient     (quotient),
    .remainder    (remainder)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: one pop per done cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        chk("quotient", 32'(quotient), 32'(e.q));
        chk("remainder", 32'(remainder), 32'(e.r));
        chk("div_by_zero", 32'(div_by_zero), 32'(e.z));
        chk("latency", 32'(cyc - e.acc), 32'(LAT));
        chk("busy_with_done", 32'(busy), 32'd0);
      end
    end
  end

  // Reference models.
  function automatic logic [23:0] int_model(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] q, r;
    if (b == 8'h00) return {16'hFFFF, a[7:0]};
    q = a / {8'h00, b};
    r = a % {8'h00, b};
    return {q, r[7:0]};
  endfunction

  function automatic logic [23:0] cl_model(input logic [15:0] a, input logic [7:0] b);
    logic [15:0] q, r;
    int d;
    if (b == 8'h00) return {16'hFFFF, a[7:0]};
    d = 0;
    for (int i = 0; i < 8; i++) if (b[i]) d = i;
    q = '0;
    r = a;
    for (int i = 15; i >= d; i--) begin
      if (r[i]) begin
        r = r ^ ({8'h00, b} << (i - d));
        q[i - d] = 1'b1;
      end
    end
    return {q, r[7:0]};
  endfunction

  task automatic push_exp(input logic [15:0] eq, input logic [7:0] er, input logic ez,
                          input int acc);
    exp_t e;
    e.q = eq; e.r = er; e.z = ez; e.acc = acc;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [15:0] a, input logic [7:0] b, input logic m,
                       input logic [15:0] eq, input logic [7:0] er, input logic ez);
    @(negedge clk);
    dividend = a;
    divisor = b;
    carry_option = m;
    start = 1'b1;
    push_exp(eq, er, ez, cyc + 1);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: %0d results outstanding after %0d cycles", sb.size(), budget);
      sb.delete();
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic m,
                        input logic [15:0] eq, input logic [7:0] er, input logic ez);
    issue(a, b, m, eq, er, ez);
    drain(LAT + 10);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_dbz"}, 32'(div_by_zero), 32'd0);
    chk({tag, "_quotient"}, 32'(quotient), 32'd0);
    chk({tag, "_remainder"}, 32'(remainder), 32'd0);
  endtask

  initial begin
    int a1;
    logic [15:0] ra;
    logic [7:0]  rb;
    logic        rm;
    logic [23:0] ex;

    // Reset state, during and after reset.
    #12;
    chk_zero_outputs("in_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("after_reset");

    // Directed vectors with hand-computed results.
    run_op(16'h03E8, 8'h07, 1'b1, 16'h008E, 8'h06, 1'b0);
    run_op(16'h2B79, 8'h83, 1'b0, 16'h0057, 8'h00, 1'b0);
    run_op(16'h2B7C, 8'h83, 1'b0, 16'h0057, 8'h05, 1'b0);
    run_op(16'hFFFF, 8'h01, 1'b1, 16'hFFFF, 8'h00, 1'b0);
    run_op(16'hFFFF, 8'h01, 1'b0, 16'hFFFF, 8'h00, 1'b0);
    run_op(16'h1234, 8'h00, 1'b1, 16'hFFFF, 8'h34, 1'b1);
    run_op(16'h1234, 8'h00, 1'b0, 16'hFFFF, 8'h34, 1'b1);
    run_op(16'h0006, 8'h07, 1'b1, 16'h0000, 8'h06, 1'b0);

    // start held high; dividend changes during RUN. Second op accepted
    // 18 cycles after the first, with the new dividend (11132/7 = 1590 r 2).
    @(negedge clk);
    dividend = 16'h03E8;
    divisor = 8'h07;
    carry_option = 1'b1;
    start = 1'b1;
    a1 = cyc + 1;
    push_exp(16'h008E, 8'h06, 1'b0, a1);
    push_exp(16'h0636, 8'h02, 1'b0, a1 + 2 * W + 2);
    repeat (3) @(negedge clk);
    dividend = 16'h2B7C;
    while (cyc < a1 + 2 * W + 2) @(negedge clk);
    start = 1'b0;
    drain(3 * LAT);

    // start pulse with other operands during busy is ignored.
    issue(16'h2B79, 8'h83, 1'b0, 16'h0057, 8'h00, 1'b0);
    repeat (4) @(negedge clk);
    dividend = 16'hAAAA;
    divisor = 8'h03;
    carry_option = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(LAT + 10);
    repeat (LAT + 4) @(negedge clk);

    // Reset at step 5 aborts; no done may follow.
    issue(16'h03E8, 8'h07, 1'b1, 16'h008E, 8'h06, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk_zero_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    run_op(16'h2B7C, 8'h83, 1'b0, 16'h0057, 8'h05, 1'b0);

    // Random vectors in both modes against the reference models.
    for (int n = 0; n < 600; n++) begin
      rm = 1'($urandom_range(0, 1));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      ex = rm ? int_model(ra, rb) : cl_model(ra, rb);
      run_op(ra, rb, rm, ex[23:8], ex[7:0], (rb == 8'h00));
    end

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
